// File: rtl/mm_ctrl_pkg.sv
// Shared constants and FSM encoding for the L1 main-memory controller.
package mm_ctrl_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int LINE_OFF = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mm_line_ram.sv
// Line storage: DEPTH x LINE_W, one synchronous write port and one registered read port.
module mm_line_ram
  import mm_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/l1_mm_ctrl.sv
// L1 line-fill / writeback controller in front of mm_line_ram.
// Define MM_CTRL_ERR_CHK_EN to enable the sticky protocol-error checker on err.
module l1_mm_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int MEM_RANGE = 256,
  parameter int RD_LAT    = 4
) (
  input  logic                master_clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   a,
  input  logic                read,
  input  logic                write,
  input  logic [LINE_W-1:0]   wd,
  output logic [LINE_W-1:0]   rd,
  output logic                valid,
  output logic                busy,
  output logic                err
);

  localparam int IDX_W = $clog2(MEM_RANGE);
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  mm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  ram_raddr;
  logic [LINE_W-1:0] ram_rdata;
  logic              accept_rd;
  logic              accept_wr;
  logic              fill_done;
  logic              unused_a;

  // Line index keeps only the low IDX_W bits of a[31:5], so addresses alias modulo MEM_RANGE.
  assign req_idx  = a[LINE_OFF +: IDX_W];
  assign unused_a = ^a;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_rd) state_d = RD_WAIT;
      RD_WAIT: if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = accept_rd ? RD_WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RD_WAIT);
    valid     = (state_q == RESP);
    fill_done = (state_q == RD_WAIT) && (cnt_q == '0);
    // A simultaneous read+write never starts a fill: it is either write-only or dropped.
    accept_rd = !busy && read && !write;
`ifdef MM_CTRL_ERR_CHK_EN
    accept_wr = !busy && write && !read;
`else
    accept_wr = !busy && write;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    rd_d  = rd_q;
    if (accept_rd) begin
      cnt_d = CNT_W'(RD_LAT - 2);
      idx_d = req_idx;
    end else if (busy && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (fill_done) begin
      rd_d = ram_rdata;
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rd_q  <= rd_d;
    end
  end

  // The RAM is read from the request address at acceptance so RD_LAT=2 still has one cycle of access.
  assign ram_raddr = accept_rd ? req_idx : idx_q;

  mm_line_ram #(
    .DEPTH (MEM_RANGE)
  ) u_ram (
    .clk_i   (master_clk),
    .we_i    (accept_wr),
    .waddr_i (req_idx),
    .wdata_i (wd),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign rd = rd_q;

`ifdef MM_CTRL_ERR_CHK_EN
  logic err_q;

  always_ff @(posedge master_clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((read && write && !busy) || (busy && (read || write))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_l1_mm_ctrl.sv
// Directed self-checking bench for l1_mm_ctrl (MEM_RANGE=256, RD_LAT=4).
module tb_l1_mm_ctrl;

  localparam int RD_LAT = 4;
  localparam logic [255:0] D_A5 = {8{32'hA5A5_A5A5}};
  localparam logic [255:0] D_L1 = {8{32'h1111_1111}};
  localparam logic [255:0] D_L3 = {8{32'h3333_3333}};
  localparam logic [255:0] D_FF = {8{32'hFFFF_FFFF}};
  localparam logic [255:0] D_77 = {8{32'h7777_7777}};
  localparam logic [255:0] D_5A = {8{32'h5A5A_5A5A}};
  localparam logic [255:0] D_C3 = {8{32'hC3C3_C3C3}};
  localparam logic [255:0] D_3C = {8{32'h3C3C_3C3C}};

  logic         master_clk;
  logic         reset;
  logic [31:0]  a;
  logic         read;
  logic         write;
  logic [255:0] wd;
  logic [255:0] rd;
  logic         valid;
  logic         busy;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  l1_mm_ctrl #(
    .MEM_RANGE (256),
    .RD_LAT    (RD_LAT)
  ) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .a          (a),
    .read       (read),
    .write      (write),
    .wd         (wd),
    .rd         (rd),
    .valid      (valid),
    .busy       (busy),
    .err        (err)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the write taken.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] data);
    a     = addr;
    wd    = data;
    write = 1'b1;
    @(negedge master_clk);
    write = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the valid cycle (the RESP cycle).
  task automatic do_read(input logic [31:0] addr, input logic [31:0] addr_wait,
                         input logic [255:0] exp, input string tag);
    int lat;
    int nbusy;
    a    = addr;
    read = 1'b1;
    @(negedge master_clk);
    read  = 1'b0;
    a     = addr_wait;
    lat   = 1;
    nbusy = 0;
    while (!valid && lat < 20) begin
      if (busy) nbusy++;
      @(negedge master_clk);
      lat++;
    end
    check({tag, "_lat"}, 256'(lat), 256'(RD_LAT));
    check({tag, "_busy_cycles"}, 256'(nbusy), 256'(RD_LAT - 1));
    check({tag, "_busy_in_resp"}, 256'(busy), 256'(0));
    check({tag, "_rd"}, rd, exp);
  endtask

  initial begin
    int npulse;
    reset = 1'b1;
    a     = '0;
    read  = 1'b0;
    write = 1'b0;
    wd    = '0;
    repeat (3) @(negedge master_clk);
    check("rst_rd", rd, '0);
    check("rst_valid", 256'(valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    reset = 1'b0;
    @(negedge master_clk);

    // Basic write then fill with latency and hold checks.
    do_write(32'h40, D_A5);
    check("wr_busy", 256'(busy), 256'(0));
    do_read(32'h40, 32'h40, D_A5, "basic");
    @(negedge master_clk);
    check("valid_one_cycle", 256'(valid), 256'(0));
    check("rd_hold", rd, D_A5);

    // Address changes during RD_WAIT must not redirect the fill.
    do_write(32'h20, D_L1);
    do_write(32'h60, D_L3);
    do_read(32'h20, 32'h60, D_L1, "addr_change");
    @(negedge master_clk);

    // Back-to-back: second read issued in the valid cycle of the first.
    do_read(32'h40, 32'h40, D_A5, "b2b_first");
    do_read(32'h60, 32'h60, D_L3, "b2b_second");
    @(negedge master_clk);
    check("b2b_after_valid", 256'(valid), 256'(0));

    // Reset two cycles after accept aborts the fill.
    a    = 32'h40;
    read = 1'b1;
    @(negedge master_clk);
    read = 1'b0;
    @(negedge master_clk);
    reset = 1'b1;
    @(negedge master_clk);
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_valid", 256'(valid), 256'(0));
    check("abort_rd", rd, '0);
    reset  = 1'b0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge master_clk);
      if (valid) npulse++;
    end
    check("abort_no_valid", 256'(npulse), 256'(0));
    do_read(32'h40, 32'h40, D_A5, "persist");
    @(negedge master_clk);

    // A write while busy is ignored (and flagged when checking is enabled).
    a    = 32'h40;
    read = 1'b1;
    @(negedge master_clk);
    read  = 1'b0;
    a     = 32'h20;
    wd    = D_FF;
    write = 1'b1;
    @(negedge master_clk);
    write  = 1'b0;
    npulse = 0;
    while (!valid && npulse < 20) begin
      @(negedge master_clk);
      npulse++;
    end
    check("busy_wr_rd", rd, D_A5);
    @(negedge master_clk);
`ifdef MM_CTRL_ERR_CHK_EN
    check("busy_wr_err", 256'(err), 256'(1));
`else
    check("busy_wr_err", 256'(err), 256'(0));
`endif
    do_read(32'h20, 32'h20, D_L1, "busy_wr_ignored");
    @(negedge master_clk);
    reset = 1'b1;
    @(negedge master_clk);
    check("err_cleared", 256'(err), 256'(0));
    reset = 1'b0;
    @(negedge master_clk);

    // Write in the RESP cycle to the line being returned.
    do_read(32'h40, 32'h40, D_A5, "resp_wr_pre");
    do_write(32'h40, D_77);
    check("resp_wr_rd_hold", rd, D_A5);
    check("resp_wr_valid", 256'(valid), 256'(0));
    do_read(32'h40, 32'h40, D_77, "resp_wr_stored");
    @(negedge master_clk);

    // Index wrap: 0x2000 aliases 0x0 with 256 lines.
    do_write(32'h2000, D_5A);
    do_read(32'h0, 32'h0, D_5A, "wrap");
    @(negedge master_clk);

    // Simultaneous read and write in IDLE.
    do_write(32'h80, D_C3);
    a     = 32'h80;
    wd    = D_3C;
    read  = 1'b1;
    write = 1'b1;
    @(negedge master_clk);
    read  = 1'b0;
    write = 1'b0;
    check("rw_no_fill", 256'(busy), 256'(0));
    repeat (2) @(negedge master_clk);
`ifdef MM_CTRL_ERR_CHK_EN
    check("rw_err", 256'(err), 256'(1));
    do_read(32'h80, 32'h80, D_C3, "rw_dropped");
    @(negedge master_clk);
    check("rw_err_sticky", 256'(err), 256'(1));
    reset = 1'b1;
    @(negedge master_clk);
    check("rw_err_reset", 256'(err), 256'(0));
    reset = 1'b0;
    @(negedge master_clk);
`else
    check("rw_err", 256'(err), 256'(0));
    do_read(32'h80, 32'h80, D_3C, "rw_write_only");
    @(negedge master_clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
